qmca_trigger: RTL

// Event-capture stage fed by qmca_conf: watches 4 ADC channels, fires on a rising threshold crossing, captures a

---
 rtl/qmca_trigger.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/qmca_trigger.sv
`default_nettype none
// ============================================================================
//  Module      : qmca_trigger
//  Description : Event-capture stage. Watches four ADC channels for a rising
//                threshold crossing, captures a fixed-length waveform of the
//                triggering channel into an internal buffer, then streams it
//                out as a header word followed by the samples (valid/ready).
//                Only one capture is in flight at a time.
//  Ports       : clk, rst (async, active-high)  - clock / hard reset
//                conf_rst                        - soft reset, synchronous
//                conf_threshold/buf_size/channel - trigger configuration
//                adc_valid, adc_data             - 4 x ADC_WIDTH sample sets
//                evt_data/valid/ready/last       - output event stream
//                sm_channel, sm_data             - channel of event / busy
//  Revision    : 1.0 - initial release
// ============================================================================
module qmca_trigger #(
    parameter int ADC_WIDTH = 14,
    parameter int BUF_DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   conf_rst,
    input  logic [ADC_WIDTH-1:0]   conf_threshold,
    input  logic [7:0]             conf_buf_size,
    input  logic [2:0]             conf_channel,
    input  logic                   adc_valid,
    input  logic [4*ADC_WIDTH-1:0] adc_data,
    output logic [15:0]            evt_data,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic                   evt_last,
    output logic [1:0]             sm_channel,
    output logic                   sm_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_READOUT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADC_WIDTH-1:0] prev_q [4];
    logic [ADC_WIDTH-1:0] prev_d [4];
    logic [1:0]           ch_q, ch_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           addr_q, addr_d;      // last buffer address written
    logic [7:0]           rd_q, rd_d;          // next sample index to present
    logic [15:0]          evt_data_q, evt_data_d;
    logic                 evt_valid_q, evt_valid_d;
    logic                 evt_last_q, evt_last_d;

    logic [ADC_WIDTH-1:0] w_cur [4];
    logic [3:0]           w_cross;
    logic                 w_trig;
    logic [1:0]           w_trig_ch;
    logic                 w_wr_en;
    logic [7:0]           w_wr_addr;
    logic [ADC_WIDTH-1:0] w_wr_data;
    logic [ADC_WIDTH-1:0] w_rd_data;

    logic [ADC_WIDTH-1:0] mem [BUF_DEPTH];

    function automatic logic [15:0] f_header(input logic [1:0] ch, input logic [7:0] len);
        return {1'b1, 5'b0, ch, len};
    endfunction

    generate
        for (genvar n = 0; n < 4; n++) begin : g_ch
            assign w_cur[n]   = adc_data[n*ADC_WIDTH +: ADC_WIDTH];
            assign w_cross[n] = adc_valid && (prev_q[n] < conf_threshold)
                                          && (w_cur[n] >= conf_threshold);
        end
    endgenerate

    // Channel selection; in all-channel mode the lowest index wins a tie,
    // hence the descending scan where later hits overwrite earlier ones.
    always_comb begin
        w_trig    = 1'b0;
        w_trig_ch = 2'd0;
        if (conf_channel == 3'd4) begin
            for (int n = 3; n >= 0; n--) begin
                if (w_cross[n]) begin
                    w_trig    = 1'b1;
                    w_trig_ch = 2'(n);
                end
            end
        end else if (!conf_channel[2]) begin
            w_trig    = w_cross[conf_channel[1:0]];
            w_trig_ch = conf_channel[1:0];
        end
    end

    // Asynchronous buffer read gives the readout path the next sample
    // without a bubble after each accepted word.
    assign w_rd_data = mem[rd_q];

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        len_d       = len_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        evt_data_d  = evt_data_q;
        evt_valid_d = evt_valid_q;
        evt_last_d  = evt_last_q;
        w_wr_en     = 1'b0;
        w_wr_addr   = addr_q;
        w_wr_data   = w_cur[ch_q];
        for (int n = 0; n < 4; n++) begin
            prev_d[n] = adc_valid ? w_cur[n] : prev_q[n];
        end

        case (state_q)
            S_IDLE: begin
                if (w_trig) begin
                    ch_d      = w_trig_ch;
                    len_d     = conf_buf_size;
                    addr_d    = 8'd0;
                    rd_d      = 8'd0;
                    w_wr_en   = 1'b1;
                    w_wr_addr = 8'd0;
                    w_wr_data = w_cur[w_trig_ch];
                    if (conf_buf_size == 8'd0) begin
                        state_d     = S_READOUT;
                        evt_valid_d = 1'b1;
                        evt_last_d  = 1'b0;
                        evt_data_d  = f_header(w_trig_ch, conf_buf_size);
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (adc_valid) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = addr_q + 8'd1;
                    addr_d    = addr_q + 8'd1;
                    if ((addr_q + 8'd1) == len_q) begin
                        state_d     = S_READOUT;
                        evt_valid_d = 1'b1;
                        evt_last_d  = 1'b0;
                        evt_data_d  = f_header(ch_q, len_q);
                    end
                end
            end
            S_READOUT: begin
                if (evt_ready) begin
                    if (evt_last_q) begin
                        state_d     = S_IDLE;
                        evt_valid_d = 1'b0;
                        evt_last_d  = 1'b0;
                        evt_data_d  = 16'd0;
                    end else begin
                        evt_data_d = {{(16-ADC_WIDTH){1'b0}}, w_rd_data};
                        evt_last_d = (rd_q == len_q);
                        rd_d       = rd_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Soft reset has the same effect as rst, one edge later.
        if (conf_rst) begin
            state_d     = S_IDLE;
            ch_d        = 2'd0;
            len_d       = 8'd0;
            addr_d      = 8'd0;
            rd_d        = 8'd0;
            evt_data_d  = 16'd0;
            evt_valid_d = 1'b0;
            evt_last_d  = 1'b0;
            w_wr_en     = 1'b0;
            for (int n = 0; n < 4; n++) begin
                prev_d[n] = '1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= 2'd0;
            len_q       <= 8'd0;
            addr_q      <= 8'd0;
            rd_q        <= 8'd0;
            evt_data_q  <= 16'd0;
            evt_valid_q <= 1'b0;
            evt_last_q  <= 1'b0;
            // All-ones history means the first sample can never cross.
            for (int n = 0; n < 4; n++) begin
                prev_q[n] <= '1;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            evt_data_q  <= evt_data_d;
            evt_valid_q <= evt_valid_d;
            evt_last_q  <= evt_last_d;
            for (int n = 0; n < 4; n++) begin
                prev_q[n] <= prev_d[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[w_wr_addr] <= w_wr_data;
        end
    end

    assign evt_data   = evt_data_q;
    assign evt_valid  = evt_valid_q;
    assign evt_last   = evt_last_q;
    assign sm_channel = ch_q;
    assign sm_data    = (state_q != S_IDLE);

endmodule
`default_nettype wire
